seq_det_scheduler: RTL and testbench

- Time-multiplexes one Mealy "11010" detection engine across NUM_CH serial bit channels.
- Keeps a per-channel saved FSM state, so each channel is detected independently as if it had its own detector.
- Grants the engine to one requesting channel per cycle (round-robin by default), reports matches with channel tag, and keeps per-channel saturating match counters.
- Sits between the serial front-ends and the status/interrupt logic.

---
 rtl/seq_det_scheduler.sv | 149 ++++++++++++++
 tb/tb_seq_det_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_scheduler.sv
// Shares one Mealy "11010" detector across NUM_CH serial channels with per-channel saved state,
// a round-robin grant, tagged match pulses and saturating counters.
// Define SEQ_SCHED_FIXED_PRIO_EN for a lowest-index-wins grant instead of round-robin.
module seq_det_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_bit,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic                      match_valid,
  output logic [$clog2(NUM_CH)-1:0] match_ch,
  input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
  input  logic                      cnt_clear,
  output logic [CNT_W-1:0]          cnt_value
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    StS0 = 3'd0,
    StS1 = 3'd1,
    StS2 = 3'd2,
    StS3 = 3'd3,
    StS4 = 3'd4
  } state_e;

  state_e           ctx_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  state_e          cur_state;
  state_e          nxt_state;
  logic            cur_bit;
  logic            hit;
  logic            match_now;
  logic            match_valid_q;
  logic [IdxW-1:0] match_ch_q;

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  // Scan from the top so the lowest requesting index is the last one written.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;

  // Search ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_CH);
      if (!gnt_found && ch_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`endif

  always_comb begin
    ch_ready = '0;
    if (gnt_found) begin
      ch_ready[gnt_idx] = 1'b1;
    end
  end

  assign cur_state = ctx_q[gnt_idx];
  assign cur_bit   = ch_bit[gnt_idx];

  always_comb begin
    nxt_state = StS0;
    hit       = 1'b0;
    case (cur_state)
      StS0: nxt_state = cur_bit ? StS1 : StS0;
      StS1: nxt_state = cur_bit ? StS2 : StS0;
      StS2: nxt_state = cur_bit ? StS2 : StS3;
      StS3: nxt_state = cur_bit ? StS4 : StS0;
      StS4: begin
        nxt_state = cur_bit ? StS2 : StS0;
        hit       = !cur_bit;
      end
      default: nxt_state = StS0;
    endcase
  end

  assign match_now = gnt_found & hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        ctx_q[i] <= StS0;
        cnt_q[i] <= '0;
      end
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
      ptr_q         <= IdxW'(NUM_CH - 1);
`endif
    end else begin
      if (gnt_found) begin
        ctx_q[gnt_idx] <= nxt_state;
      end
      // Clear beats a same-cycle increment on the same channel.
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (cnt_clear && (cnt_sel == IdxW'(i))) begin
          cnt_q[i] <= '0;
        end else if (match_now && (gnt_idx == IdxW'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      match_valid_q <= match_now;
      if (match_now) begin
        match_ch_q <= gnt_idx;
      end
`ifndef SEQ_SCHED_FIXED_PRIO_EN
      if (gnt_found) begin
        ptr_q <= gnt_idx;
      end
`endif
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cnt_sel == IdxW'(i)) begin
        cnt_value = cnt_q[i];
      end
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: vector table plus hand sequences for interleave,
// round-robin wrap, saturation/clear races and async reset.
module tb_seq_det_scheduler;

  logic       clk;
  logic       reset_n;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [3:0] ch_ready;
  logic [3:0] ch_ready_s;
  logic       match_valid;
  logic       match_valid_s;
  logic [1:0] match_ch;
  logic [1:0] match_ch_s;
  logic [1:0] cnt_sel;
  logic       cnt_clear;
  logic [7:0] cnt_value;
  logic [1:0] cnt_value_s;

  int n_cmp = 0;
  int n_bad = 0;

  seq_det_scheduler #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_valid   (ch_valid),
    .ch_bit     (ch_bit),
    .ch_ready   (ch_ready),
    .match_valid(match_valid),
    .match_ch   (match_ch),
    .cnt_sel    (cnt_sel),
    .cnt_clear  (cnt_clear),
    .cnt_value  (cnt_value)
  );

  // Same stimulus, 2-bit counters to exercise saturation.
  seq_det_scheduler #(.NUM_CH(4), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_valid   (ch_valid),
    .ch_bit     (ch_bit),
    .ch_ready   (ch_ready_s),
    .match_valid(match_valid_s),
    .match_ch   (match_ch_s),
    .cnt_sel    (cnt_sel),
    .cnt_clear  (cnt_clear),
    .cnt_value  (cnt_value_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] bits;
    logic       clr;
    logic [1:0] sel;
    logic [3:0] ready;
    logic       mv;
    logic [1:0] mch;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] b, input logic c,
                              input logic [1:0] s, input logic [3:0] r, input logic m,
                              input logic [1:0] mc, input logic [7:0] cn);
    vec_t t;
    t.valid = v; t.bits = b; t.clr = c; t.sel = s;
    t.ready = r; t.mv = m; t.mch = mc; t.cnt = cn;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic c,
                       input logic [1:0] s);
    @(negedge clk);
    ch_valid  = v;
    ch_bit    = b;
    cnt_clear = c;
    cnt_sel   = s;
    #1;
  endtask

  // Single-channel bit; other lanes carry the inverse so a wrong-lane read shows up.
  task automatic bit_on(input int ch, input logic b, input logic c, input int s);
    logic [3:0] oh;
    oh = 4'(1 << ch);
    drive(oh, b ? oh : ~oh, c, 2'(s));
    check($sformatf("bit_on ready ch%0d", ch), 32'(ch_ready), 32'(oh));
  endtask

  task automatic feed(input int ch, input logic [4:0] pat, input int nbits, input logic clr_last,
                      input int s);
    for (int i = 0; i < nbits; i++) begin
      bit_on(ch, pat[nbits-1-i], clr_last && (i == nbits - 1), s);
    end
  endtask

  initial begin
    logic [4:0] seq;
    logic [7:0] exp_cnt [4];
    logic [3:0] exp_wrap [3];

    reset_n   = 1'b0;
    ch_valid  = '0;
    ch_bit    = '0;
    cnt_clear = 1'b0;
    cnt_sel   = '0;
    #3;
    check("reset ready", 32'(ch_ready), 0);
    check("reset match_valid", 32'(match_valid), 0);
    check("reset match_ch", 32'(match_ch), 0);
    check("reset cnt", 32'(cnt_value), 0);
    check("reset sat cnt", 32'(cnt_value_s), 0);
    #8 reset_n = 1'b1;

    // Single channel 11010 on ch0.
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b1110, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b1110, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1));
    // ch2 streams 1101011010: matches after bits 5 and 10.
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b1011, 0, 2, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b1011, 0, 2, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 1, 2, 1));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 0, 2, 1));
    tbl.push_back(mk(4'b0100, 4'b1011, 0, 2, 4'b0100, 0, 2, 1));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 2, 4'b0100, 0, 2, 1));
    tbl.push_back(mk(4'b0100, 4'b1011, 0, 2, 4'b0100, 0, 2, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 2, 4'b0000, 1, 2, 2));
    // ch1 streams 11011010: S4 on 1 must go to S2, single match at the end.
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b1101, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b1101, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0010, 4'b1101, 0, 1, 4'b0010, 0, 2, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 4'b0000, 1, 1, 1));
    // Park the pointer on ch3 with a harmless 0 bit.
    tbl.push_back(mk(4'b1000, 4'b0111, 0, 3, 4'b1000, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].bits, tbl[i].clr, tbl[i].sel);
      check($sformatf("vec%0d ready", i), 32'(ch_ready), 32'(tbl[i].ready));
      check($sformatf("vec%0d match_valid", i), 32'(match_valid), 32'(tbl[i].mv));
      check($sformatf("vec%0d match_ch", i), 32'(match_ch), 32'(tbl[i].mch));
      check($sformatf("vec%0d cnt", i), 32'(cnt_value), 32'(tbl[i].cnt));
    end

    // Interleave: all valid, grants rotate 0..3, each channel sees 11010.
    seq = 5'b11010;
    for (int j = 0; j < 20; j++) begin
      logic [3:0] oh;
      oh = 4'(1 << (j % 4));
      drive(4'b1111, seq[4 - j / 4] ? oh : ~oh, 0, 0);
      check($sformatf("ilv%0d ready", j), 32'(ch_ready), 32'(oh));
      check($sformatf("ilv%0d match_valid", j), 32'(match_valid), (j >= 17) ? 1 : 0);
      check($sformatf("ilv%0d match_ch", j), 32'(match_ch), (j >= 17) ? 32'(j - 17) : 1);
    end
    drive(4'b0000, 4'b0000, 0, 0);
    check("ilv tail match_valid", 32'(match_valid), 1);
    check("ilv tail match_ch", 32'(match_ch), 3);
    exp_cnt[0] = 2; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 1;
    for (int s = 0; s < 4; s++) begin
      drive(4'b0000, 4'b0000, 0, 2'(s));
      check($sformatf("ilv cnt ch%0d", s), 32'(cnt_value), 32'(exp_cnt[s]));
      check($sformatf("ilv sat cnt ch%0d", s), 32'(cnt_value_s), 32'(exp_cnt[s]));
    end

    // Round-robin wrap with ch1 and ch3 requesting, pointer on 3.
    exp_wrap[0] = 4'b0010; exp_wrap[1] = 4'b1000; exp_wrap[2] = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      drive(4'b1010, 4'b0000, 0, 0);
      check($sformatf("wrap%0d ready", j), 32'(ch_ready), 32'(exp_wrap[j]));
    end

    // Saturation: ch0 goes 2 -> 3 -> 4 (sat build stops at 3).
    feed(0, 5'b11010, 5, 1'b0, 0);
    drive(4'b0000, 4'b0000, 0, 0);
    check("sat1 match_valid", 32'(match_valid), 1);
    check("sat1 cnt", 32'(cnt_value), 3);
    check("sat1 sat cnt", 32'(cnt_value_s), 3);
    feed(0, 5'b11010, 5, 1'b0, 0);
    drive(4'b0000, 4'b0000, 0, 0);
    check("sat2 cnt", 32'(cnt_value), 4);
    check("sat2 sat cnt", 32'(cnt_value_s), 3);

    // Clear and match on ch0 in the same cycle: clear wins, pulse still emitted.
    feed(0, 5'b01101, 4, 1'b0, 0);
    bit_on(0, 1'b0, 1'b1, 0);
    check("race pre-update cnt", 32'(cnt_value), 4);
    check("race pre-update sat cnt", 32'(cnt_value_s), 3);
    drive(4'b0000, 4'b0000, 0, 0);
    check("race match_valid", 32'(match_valid), 1);
    check("race match_ch", 32'(match_ch), 0);
    check("race cnt", 32'(cnt_value), 0);
    check("race sat cnt", 32'(cnt_value_s), 0);

    // ch1 left at S4; ch2 matches while ch1 counter is cleared.
    feed(1, 5'b01101, 4, 1'b0, 1);
    feed(2, 5'b11010, 5, 1'b1, 1);
    @(negedge clk);
    ch_valid  = '0;
    ch_bit    = '0;
    cnt_clear = 1'b0;
    cnt_sel   = 2'd1;
    #1;
    check("cross match_valid", 32'(match_valid), 1);
    check("cross match_ch", 32'(match_ch), 2);
    check("cross cleared ch1", 32'(cnt_value), 0);
    cnt_sel = 2'd2;
    #1;
    check("cross incremented ch2", 32'(cnt_value), 4);
    check("cross sat ch2", 32'(cnt_value_s), 3);

    // Async reset with a match pulse pending.
    #1 reset_n = 1'b0;
    #1;
    check("areset match_valid", 32'(match_valid), 0);
    check("areset match_ch", 32'(match_ch), 0);
    check("areset cnt", 32'(cnt_value), 0);
    check("areset sat cnt", 32'(cnt_value_s), 0);
    check("areset ready", 32'(ch_ready), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    drive(4'b0011, 4'b0000, 0, 1);
    check("post-reset ptr ready", 32'(ch_ready), 32'(4'b0001));
    drive(4'b0010, 4'b1101, 0, 1);
    check("post-reset ch1 ready", 32'(ch_ready), 32'(4'b0010));
    check("post-reset match_valid a", 32'(match_valid), 0);
    drive(4'b0000, 4'b0000, 0, 1);
    check("post-reset match_valid b", 32'(match_valid), 0);
    check("post-reset cnt ch1", 32'(cnt_value), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
